sp3_rx_link_ctrl: RTL

SP3_RX_LINK_CTRL -- requirements
Module: sp3_rx_link_ctrl

---
 rtl/sp3_rx_link_ctrl_pkg.sv | 26 ++
 rtl/sp3_rx_link_ctrl_if.sv | 33 +++
 rtl/sp3_rx_link_ctrl_timer.sv | 29 ++
 rtl/sp3_rx_link_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sp3_rx_link_ctrl_pkg.sv
// Shared types for the SP3 uplink receiver link controller:
// state encoding, status bit positions and counter widths.
package sp3_rx_ctrl_pkg;

    localparam int STAT_RDY_A   = 0;
    localparam int STAT_RDY_B   = 1;
    localparam int STAT_MGT_RDY = 2;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 3;
    localparam int SLIP_W  = 6;
    localparam int LOSS_W  = 16;
    localparam int TMR_W   = 24;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_MGT  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_SLIP      = 3'd4,
        ST_LOCKED    = 3'd5,
        ST_RETRY     = 3'd6,
        ST_FAIL      = 3'd7
    } state_e;

endpackage

// File: rtl/sp3_rx_link_ctrl_if.sv
// Control/status bundle between the link controller and its host
// plus the receiver it drives.
interface sp3_rx_link_ctrl_if;
    import sp3_rx_ctrl_pkg::*;

    logic               start_i;
    logic               abort_i;
    logic [7:0]         status_i;
    logic               uplink_rst_o;
    logic               pulse_bitslip_a_o;
    logic               pulse_bitslip_b_o;
    logic               link_up_o;
    logic               fail_o;
    logic [STATE_W-1:0] state_o;
    logic [RETRY_W-1:0] retry_cnt_o;
    logic [SLIP_W-1:0]  slip_cnt_o;
    logic [LOSS_W-1:0]  loss_cnt_o;

    modport master (
        output start_i, abort_i, status_i,
        input  uplink_rst_o, pulse_bitslip_a_o, pulse_bitslip_b_o,
        input  link_up_o, fail_o, state_o,
        input  retry_cnt_o, slip_cnt_o, loss_cnt_o
    );

    modport slave (
        input  start_i, abort_i, status_i,
        output uplink_rst_o, pulse_bitslip_a_o, pulse_bitslip_b_o,
        output link_up_o, fail_o, state_o,
        output retry_cnt_o, slip_cnt_o, loss_cnt_o
    );

endinterface

// File: rtl/sp3_rx_link_ctrl_timer.sv
// Reloadable down-counter shared by every timed state of the link
// controller; expired is high while the count sits at zero.
module sp3_rx_timer
    import sp3_rx_ctrl_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sp3_rx_link_ctrl.sv
// Bring-up and lock supervisor for the two SP3 uplink channels.
// Optional lock-loss counter: define SP3_RX_LOSS_CNT_EN.
module sp3_rx_link_ctrl
    import sp3_rx_ctrl_pkg::*;
#(
    parameter int RST_CYCLES        = 16,
    parameter int MGT_TIMEOUT       = 100000,
    parameter int LOCK_TIMEOUT      = 4096,
    parameter int SLIP_PULSE_CYCLES = 4,
    parameter int MAX_SLIPS         = 32,
    parameter int MAX_RETRIES       = 4
) (
    input  logic               axi_clk,
    input  logic               reset,
    sp3_rx_link_ctrl_if.slave  link
);

    // Timer loads are count-1 so a state lasts exactly N cycles.
    localparam logic [TMR_W-1:0] RST_LD  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] MGT_LD  = TMR_W'(MGT_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SLIP_LD = TMR_W'(SLIP_PULSE_CYCLES - 1);
    localparam logic [SLIP_W-1:0]  SLIP_MAX  = SLIP_W'(MAX_SLIPS);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    state_e             state, state_n;
    logic [RETRY_W-1:0] retry_cnt, retry_nx;
    logic [SLIP_W-1:0]  slip_cnt;
    logic               slip_b, slip_b_n;
    logic               tmr_load, tmr_exp;
    logic [TMR_W-1:0]   tmr_val;
    logic               retry_inc, retry_clr, slip_inc, slip_clr;
    logic               rdy_a, rdy_b, mgt;
    logic               rst_q, bs_a_q, bs_b_q, link_q, fail_q;
    logic               unused_status;

    assign rdy_a    = link.status_i[STAT_RDY_A];
    assign rdy_b    = link.status_i[STAT_RDY_B];
    assign mgt      = link.status_i[STAT_MGT_RDY];
    assign retry_nx = retry_cnt + 1'b1;
    assign slip_b_n = slip_inc ? ~rdy_b : slip_b;
    assign unused_status = ^link.status_i[7:3];

    sp3_rx_timer #(.W(TMR_W)) u_timer (
        .clk      (axi_clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        slip_inc  = 1'b0;
        slip_clr  = 1'b0;
        if (link.abort_i) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (link.start_i) begin
                        state_n   = ST_RST;
                        retry_clr = 1'b1;
                    end
                end
                ST_RST: begin
                    if (tmr_exp) begin
                        state_n  = ST_WAIT_MGT;
                        tmr_load = 1'b1;
                        tmr_val  = MGT_LD;
                    end
                end
                ST_WAIT_MGT: begin
                    if (mgt) begin
                        state_n  = ST_WAIT_LOCK;
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LD;
                    end else if (tmr_exp) begin
                        state_n = ST_RETRY;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!mgt) begin
                        state_n = ST_RETRY;
                    end else if (rdy_a && rdy_b) begin
                        state_n   = ST_LOCKED;
                        retry_clr = 1'b1;
                    end else if (tmr_exp) begin
                        if ((rdy_a ^ rdy_b) && slip_cnt < SLIP_MAX) begin
                            state_n  = ST_SLIP;
                            tmr_load = 1'b1;
                            tmr_val  = SLIP_LD;
                            slip_inc = 1'b1;
                        end else begin
                            state_n = ST_RETRY;
                        end
                    end
                end
                ST_SLIP: begin
                    if (tmr_exp) begin
                        state_n  = ST_WAIT_LOCK;
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LD;
                    end
                end
                ST_LOCKED: begin
                    if (!(rdy_a && rdy_b && mgt)) begin
                        state_n = ST_RST;
                    end
                end
                ST_RETRY: begin
                    retry_inc = 1'b1;
                    slip_clr  = 1'b1;
                    state_n   = (retry_nx == RETRY_MAX) ? ST_FAIL : ST_RST;
                end
                ST_FAIL: begin
                    if (link.start_i) begin
                        state_n   = ST_RST;
                        retry_clr = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        // Every way into RST starts a fresh attempt.
        if (state_n == ST_RST && state != ST_RST) begin
            tmr_load = 1'b1;
            tmr_val  = RST_LD;
            slip_clr = 1'b1;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (reset) begin
            retry_cnt <= '0;
            slip_cnt  <= '0;
            slip_b    <= 1'b0;
            rst_q     <= 1'b0;
            bs_a_q    <= 1'b0;
            bs_b_q    <= 1'b0;
            link_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            if (retry_clr) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_nx;
            end
            if (slip_clr) begin
                slip_cnt <= '0;
            end else if (slip_inc) begin
                slip_cnt <= slip_cnt + 1'b1;
            end
            slip_b <= slip_b_n;
            rst_q  <= (state_n == ST_RST);
            bs_a_q <= (state_n == ST_SLIP) && !slip_b_n;
            bs_b_q <= (state_n == ST_SLIP) && slip_b_n;
            link_q <= (state_n == ST_LOCKED);
            fail_q <= (state_n == ST_FAIL);
        end
    end

`ifdef SP3_RX_LOSS_CNT_EN
    logic [LOSS_W-1:0] loss_cnt;

    always_ff @(posedge axi_clk) begin
        if (reset) begin
            loss_cnt <= '0;
        end else if (state == ST_LOCKED && state_n == ST_RST
                     && loss_cnt != '1) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign link.loss_cnt_o = loss_cnt;
`else
    assign link.loss_cnt_o = '0;
`endif

    assign link.uplink_rst_o      = rst_q;
    assign link.pulse_bitslip_a_o = bs_a_q;
    assign link.pulse_bitslip_b_o = bs_b_q;
    assign link.link_up_o         = link_q;
    assign link.fail_o            = fail_q;
    assign link.state_o           = state;
    assign link.retry_cnt_o       = retry_cnt;
    assign link.slip_cnt_o        = slip_cnt;

endmodule
